// File: rtl/c_element_pipeline.sv
// c_element_pipeline: DEPTH-stage Muller C-element handshake FIFO with WIDTH-bit bundled data.
// Define SYNC_IN_EN to pass req_in/ack_in through 2-flop synchronisers.
module c_element_pipeline #(
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 8,
  parameter bit FOUR_PHASE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_out,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_in,
  output logic             busy
);
  logic req_s, ack_s;
`ifdef SYNC_IN_EN
  logic [1:0] req_q, ack_q;
  always_ff @(posedge clk)
    if (rst) begin
      req_q <= '0;
      ack_q <= '0;
    end else begin
      req_q <= {req_q[0], req_in};
      ack_q <= {ack_q[0], ack_in};
    end
  assign req_s = req_q[1];
  assign ack_s = ack_q[1];
`else
  assign req_s = req_in;
  assign ack_s = ack_in;
`endif
  logic [DEPTH-1:0] c, a, b, nc, we;
  logic [DEPTH-1:0][WIDTH-1:0] d, din;
  assign a   = {c[DEPTH-2:0], req_s};
  assign b   = ~{ack_s, c[DEPTH-1:1]};
  // C-element: follow the inputs when they agree, otherwise hold
  assign nc  = (a & b) | (c & (a | b));
  assign we  = FOUR_PHASE ? (nc & ~c) : (nc ^ c);
  assign din = {d[DEPTH-2:0], data_in};
  always_ff @(posedge clk)
    if (rst) begin
      c <= '0;
      d <= '0;
    end else begin
      c <= nc;
      for (int i = 0; i < DEPTH; i++)
        if (we[i]) d[i] <= din[i];
    end
  assign ack_out  = c[0];
  assign req_out  = c[DEPTH-1];
  assign data_out = d[DEPTH-1];
  assign busy     = |(c ^ {ack_in, c[DEPTH-1:1]});
endmodule

// File: tb/tb_c_element_pipeline.sv
// tb_c_element_pipeline: scoreboard bench for two-phase and four-phase pipeline instances.
module tb_c_element_pipeline;
`ifdef SYNC_IN_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       req_in_t = 1'b0, ack_in_t = 1'b0, ack_out_t, req_out_t, busy_t;
  logic [7:0] data_in_t = 8'h00, data_out_t;
  logic       req_in_f = 1'b0, ack_in_f = 1'b0, ack_out_f, req_out_f, busy_f;
  logic [7:0] data_in_f = 8'h00, data_out_f;
  c_element_pipeline #(.DEPTH(4), .WIDTH(8), .FOUR_PHASE(1'b0)) dut_t (
    .clk(clk), .rst(rst), .req_in(req_in_t), .data_in(data_in_t), .ack_out(ack_out_t),
    .req_out(req_out_t), .data_out(data_out_t), .ack_in(ack_in_t), .busy(busy_t));
  c_element_pipeline #(.DEPTH(4), .WIDTH(8), .FOUR_PHASE(1'b1)) dut_f (
    .clk(clk), .rst(rst), .req_in(req_in_f), .data_in(data_in_f), .ack_out(ack_out_f),
    .req_out(req_out_f), .data_out(data_out_f), .ack_in(ack_in_f), .busy(busy_f));
  int tests = 0, fails = 0;
  logic [7:0] q_t[$], q_f[$];
  logic prev_t = 1'b0, prev_f = 1'b0;
  logic [7:0] last_f = 8'h00;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst) begin
      prev_t = 1'b0;
      prev_f = 1'b0;
      last_f = 8'h00;
    end else begin
      if (req_out_t !== prev_t) begin
        prev_t = req_out_t;
        chk("t_token_expected", 32'(q_t.size() != 0), 1);
        if (q_t.size() != 0) chk("t_data", data_out_t, q_t.pop_front());
      end
      if (req_out_f !== prev_f) begin
        prev_f = req_out_f;
        if (req_out_f) begin
          chk("f_token_expected", 32'(q_f.size() != 0), 1);
          if (q_f.size() != 0) begin
            last_f = q_f.pop_front();
            chk("f_data", data_out_f, last_f);
          end
        end else chk("f_rtz_hold", data_out_f, last_f);
      end
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_ack_t(input string n);
    int k = 0;
    while (ack_out_t !== req_in_t && k < 40) begin cyc(1); k++; end
    chk(n, 32'(ack_out_t === req_in_t), 1);
  endtask
  task automatic send_t(input logic [7:0] v);
    data_in_t = v;
    req_in_t = ~req_in_t;
    q_t.push_back(v);
    wait_ack_t("t_ack");
  endtask
  task automatic drain_t(input int n);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (req_out_t === ack_in_t && k < 40) begin cyc(1); k++; end
      chk("t_avail", 32'(req_out_t !== ack_in_t), 1);
      ack_in_t = ~ack_in_t;
      cyc(1);
    end
  endtask
  task automatic wait_ack_f(input string n, input logic lvl);
    int k = 0;
    while (ack_out_f !== lvl && k < 40) begin cyc(1); k++; end
    chk(n, ack_out_f, lvl);
  endtask
  task automatic wait_req_f(input string n, input logic lvl);
    int k = 0;
    while (req_out_f !== lvl && k < 40) begin cyc(1); k++; end
    chk(n, req_out_f, lvl);
  endtask
  task automatic send_f(input logic [7:0] v);
    data_in_f = v;
    req_in_f = 1'b1;
    q_f.push_back(v);
    wait_ack_f("f_ack", 1'b1);
    req_in_f = 1'b0;
    data_in_f = 8'hFF;
    wait_ack_f("f_ack_rtz", 1'b0);
  endtask
  task automatic consume_f();
    wait_req_f("f_req", 1'b1);
    ack_in_f = 1'b1;
    wait_req_f("f_req_rtz", 1'b0);
    ack_in_f = 1'b0;
  endtask
  initial begin
    logic held;
    int n;
    rst = 1'b1; req_in_t = 1'b1; req_in_f = 1'b1;
    cyc(2);
    chk("rst_ack", ack_out_t, 0);
    chk("rst_req", req_out_t, 0);
    chk("rst_data", data_out_t, 0);
    chk("rst_busy", busy_t, 0);
    rst = 1'b0;
    cyc(1 + SL);
    chk("rst_rel_ack_t", ack_out_t, 1);
    chk("rst_rel_ack_f", ack_out_f, 1);
    rst = 1'b1; req_in_t = 1'b0; req_in_f = 1'b0;
    q_t.delete(); q_f.delete();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    data_in_t = 8'hA5; req_in_t = 1'b1; q_t.push_back(8'hA5);
    cyc(1 + SL);
    chk("t1_ack", ack_out_t, 1);
    cyc(2);
    chk("t1_req_early", req_out_t, 0);
    cyc(1);
    chk("t1_req", req_out_t, 1);
    chk("t1_data", data_out_t, 8'hA5);
    chk("t1_busy", busy_t, 1);
    ack_in_t = 1'b1;
    cyc(1 + SL);
    chk("t1_idle", busy_t, 0);
    for (int i = 0; i < 4; i++) send_t(8'(8'h11 * (i + 1)));
    data_in_t = 8'h55; req_in_t = ~req_in_t; q_t.push_back(8'h55);
    held = 1'b1;
    repeat (20) begin cyc(1); if (ack_out_t === req_in_t) held = 1'b0; end
    chk("t_bp_hold", held, 1);
    ack_in_t = ~ack_in_t;
    n = 0;
    while (ack_out_t !== req_in_t && n < 20) begin cyc(1); n++; end
    chk("t_bp_release", 32'(n <= 4 + SL), 1);
    drain_t(4);
    chk("t_fill_queue", q_t.size(), 0);
    chk("t_fill_busy", busy_t, 0);
    for (int i = 0; i < 4; i++) send_t(8'(8'h61 + i));
    cyc(8 + 2 * SL);
    data_in_t = 8'h65; req_in_t = ~req_in_t; ack_in_t = ~ack_in_t; q_t.push_back(8'h65);
    wait_ack_t("t_sim_ack");
    data_in_t = 8'h66; req_in_t = ~req_in_t; q_t.push_back(8'h66);
    held = 1'b1;
    repeat (10) begin cyc(1); if (ack_out_t === req_in_t) held = 1'b0; end
    chk("t_sim_full", held, 1);
    drain_t(5);
    chk("t_sim_queue", q_t.size(), 0);
    send_f(8'h3C);
    wait_req_f("f1_req", 1'b1);
    chk("f1_data", data_out_f, 8'h3C);
    ack_in_f = 1'b1;
    wait_req_f("f1_req_rtz", 1'b0);
    chk("f1_data_rtz", data_out_f, 8'h3C);
    ack_in_f = 1'b0;
    cyc(4 + SL);
    send_f(8'hA1);
    send_f(8'hA2);
    data_in_f = 8'hA3; req_in_f = 1'b1; q_f.push_back(8'hA3);
    held = 1'b1;
    repeat (20) begin cyc(1); if (ack_out_f) held = 1'b0; end
    chk("f_cap_hold", held, 1);
    consume_f();
    wait_ack_f("f3_ack", 1'b1);
    req_in_f = 1'b0;
    wait_ack_f("f3_rtz", 1'b0);
    consume_f();
    consume_f();
    chk("f_queue", q_f.size(), 0);
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end
endmodule
